// File: rtl/tt_um_jimktrains_vslc_servo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tt_um_jimktrains_vslc_servo_rx
//  Purpose  : Servo-style PWM pulse decoder. Measures high width and
//             rise-to-rise period of an external pulse line in servo_clk
//             ticks and decodes each pulse into one bit by threshold compare.
//  Ports    : clk, rst_n (sync, active-low)  - clock / reset
//             servo_clk                      - tick source (rising edge = tick)
//             servo_enabled                  - 0 holds the block in reset
//             servo_input                    - asynchronous PWM line
//             servo_threshold_val[4:0]       - value = (width > threshold)
//             servo_timeout_val[7:0]         - tick limit, 0 disables timeout
//             servo_value, servo_width[7:0], servo_period[7:0],
//             servo_valid (1-clk strobe), servo_timeout (level)
//  Options  : VSLC_SERVO_RX_FILTER_EN - 3-sample glitch filter on the line
//  Revision : 1.0 - initial release
// ============================================================================
module tt_um_jimktrains_vslc_servo_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       servo_clk,
    input  logic       servo_enabled,
    input  logic       servo_input,
    input  logic [4:0] servo_threshold_val,
    input  logic [7:0] servo_timeout_val,
    output logic       servo_value,
    output logic [7:0] servo_width,
    output logic [7:0] servo_period,
    output logic       servo_valid,
    output logic       servo_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_servo_clk_prev;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_line_prev;

    logic        w_clear;
    logic        w_tick;
    logic        w_line;
    logic        w_rise;
    logic        w_fall;
    logic        w_to_hit;

    assign w_clear = !rst_n || !servo_enabled;

    // The previous servo_clk sample keeps tracking through reset so the
    // first tick after release is not a false edge.
    always_ff @(posedge clk) begin
        r_servo_clk_prev <= servo_clk;
    end

    assign w_tick = servo_clk & ~r_servo_clk_prev;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= servo_input;
            r_sync2 <= r_sync1;
        end
    end

`ifdef VSLC_SERVO_RX_FILTER_EN
    // The line follows the synchronizer only once three consecutive samples
    // agree; otherwise it holds its last value. The agreeing sample is used
    // combinationally so the filter costs two cycles, not three.
    logic r_hist1;
    logic r_hist2;
    logic r_filt;
    logic w_agree;

    assign w_agree = (r_sync2 == r_hist1) && (r_hist1 == r_hist2);
    assign w_line  = w_agree ? r_sync2 : r_filt;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_filt  <= w_line;
        end
    end
`else
    assign w_line = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_line_prev <= 1'b0;
        end else begin
            r_line_prev <= w_line;
        end
    end

    assign w_rise   = w_line & ~r_line_prev;
    assign w_fall   = ~w_line & r_line_prev;
    assign w_to_hit = (servo_timeout_val != 8'd0) && (r_cnt == servo_timeout_val);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            servo_value   <= 1'b0;
            servo_width   <= 8'd0;
            servo_period  <= 8'd0;
            servo_valid   <= 1'b0;
            servo_timeout <= 1'b0;
        end else begin
            servo_valid <= 1'b0;

            // A line rise restarts the count and swallows a coincident tick.
            if (w_rise) begin
                r_cnt <= 8'd0;
            end else if (w_tick && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Wait for the line to be low so a pulse already in
                    // progress at reset/enable is never measured.
                    if (!w_line) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        servo_width   <= r_cnt;
                        servo_value   <= (r_cnt > {3'b000, servo_threshold_val});
                        servo_valid   <= 1'b1;
                        servo_timeout <= 1'b0;
                        r_state       <= ST_LOW;
                    end else if (w_to_hit) begin
                        servo_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        servo_period <= r_cnt;
                        r_state      <= ST_HIGH;
                    end else if (w_to_hit) begin
                        servo_timeout <= 1'b1;
                        r_state       <= ST_ARMED;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jimktrains_vslc_servo_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tt_um_jimktrains_vslc_servo_rx
//  Purpose  : Self-checking bench for the servo pulse decoder. servo_clk
//             ticks once every 4 clk; pulses are described by their input
//             high/low lengths and the expected outputs are derived by
//             counting ticks between the line edges seen by the decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tt_um_jimktrains_vslc_servo_rx;

`ifdef VSLC_SERVO_RX_FILTER_EN
    localparam int D = 4;   // input change to the clk edge where the FSM sees it
`else
    localparam int D = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       servo_clk = 1'b0;
    logic       servo_enabled = 1'b1;
    logic       servo_input = 1'b0;
    logic [4:0] thr = 5'd5;
    logic [7:0] to_val = 8'd0;
    logic       servo_value;
    logic [7:0] servo_width;
    logic [7:0] servo_period;
    logic       servo_valid;
    logic       servo_timeout;

    tt_um_jimktrains_vslc_servo_rx dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .servo_clk           (servo_clk),
        .servo_enabled       (servo_enabled),
        .servo_input         (servo_input),
        .servo_threshold_val (thr),
        .servo_timeout_val   (to_val),
        .servo_value         (servo_value),
        .servo_width         (servo_width),
        .servo_period        (servo_period),
        .servo_valid         (servo_valid),
        .servo_timeout       (servo_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;          // index of the next clk edge to be driven

    // Reference model state
    int m_width = 0;
    int m_period = 0;
    bit m_value = 1'b0;
    bit m_to = 1'b0;
    bit m_armed = 1'b0;     // a rise would start a measured pulse
    bit m_from_low = 1'b0;  // a rise would also produce a period
    int m_last_er = 0;      // edge of the last measured rise

    // A tick is seen at edge j when servo_clk goes 0 -> 1 between edges.
    function automatic bit tk(int j);
        return (j >= 1) && ((j % 4) == 0);
    endfunction

    // Ticks strictly between two edges, saturating like an 8-bit counter.
    function automatic int ticks(int lo_ex, int hi_ex);
        int n = 0;
        for (int j = lo_ex + 1; j < hi_ex; j++) if (tk(j)) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic step(input bit v);
        servo_input = v;
        servo_clk   = ((k % 4) < 2);
        @(posedge clk);
        #1;
        k++;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input bit exp_valid);
        checks++;
        assert (servo_valid === exp_valid) else begin
            errors++;
            $error("FAIL valid @edge %0d: got %b want %b", k - 1, servo_valid, exp_valid);
        end
        checks++;
        assert (servo_width === 8'(m_width)) else begin
            errors++;
            $error("FAIL width @edge %0d: got %0d want %0d", k - 1, servo_width, m_width);
        end
        checks++;
        assert (servo_period === 8'(m_period)) else begin
            errors++;
            $error("FAIL period @edge %0d: got %0d want %0d", k - 1, servo_period, m_period);
        end
        checks++;
        assert (servo_value === m_value) else begin
            errors++;
            $error("FAIL value @edge %0d: got %b want %b", k - 1, servo_value, m_value);
        end
        checks++;
        assert (servo_timeout === m_to) else begin
            errors++;
            $error("FAIL timeout @edge %0d: got %b want %b", k - 1, servo_timeout, m_to);
        end
    endtask

    // Constant input with no expected decoder event.
    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            step(v);
            check_outs(1'b0);
        end
        if (!v && (n > D) && rst_n && servo_enabled) m_armed = 1'b1;
    endtask

    // Pad with low cycles so that the next rise is seen at an edge with
    // the given phase relative to the tick grid.
    task automatic align(input int phase);
        int n;
        n = (((phase - (k + D)) % 4) + 4) % 4;
        if (n > 0) hold(1'b0, n);
    endtask

    task automatic model_clear();
        m_width = 0; m_period = 0; m_value = 1'b0; m_to = 1'b0;
        m_armed = 1'b0; m_from_low = 1'b0;
    endtask

    // One input pulse: hi cycles high then lo cycles low (lo > D).
    task automatic pulse(input int hi, input int lo);
        int a, b, er, ef, e_to, w, per;
        bit meas, upd_per, ev;
        a = k; b = k + hi; er = a + D; ef = b + D;
        meas = m_armed; e_to = -1;
        if (meas && (to_val != 8'd0)) begin
            for (int e = er + 1; e < ef; e++) begin
                if (ticks(er, e) == int'(to_val)) begin
                    e_to = e;
                    break;
                end
            end
        end
        w = ticks(er, ef);
        per = ticks(m_last_er, er);
        upd_per = meas && m_from_low;
        for (int i = 0; i < hi + lo; i++) begin
            step(i < hi);
            ev = 1'b0;
            if ((k - 1 == er) && upd_per) m_period = per;
            if (k - 1 == e_to) m_to = 1'b1;
            if ((k - 1 == ef) && meas && (e_to < 0)) begin
                m_width = w;
                m_value = (w > int'(thr));
                m_to = 1'b0;
                ev = 1'b1;
            end
            check_outs(ev);
        end
        if (meas) begin
            m_from_low = (e_to < 0);
            m_last_er = er;
        end
        m_armed = 1'b1;
    endtask

    initial begin
        int hi, lo, er;
        bit bv;

        // Reset state
        rst_n = 1'b0;
        model_clear();
        hold(1'b0, 4);
        rst_n = 1'b1;
        hold(1'b0, 6);

        // Decode at threshold 5: 8 ticks -> 1, 5 ticks -> 0; then 20-tick period
        thr = 5'd5;
        align(2);
        pulse(32, 32);
        chk("width_8", int'(servo_width), 8);
        chk("value_8", int'(servo_value), 1);
        pulse(20, 60);
        chk("width_5", int'(servo_width), 5);
        chk("value_5", int'(servo_value), 0);
        pulse(32, 48);
        pulse(32, 48);
        chk("period_20", int'(servo_period), 20);

        // Rise coincident with a tick: that tick is dropped
        align(0);
        pulse(8, 12);
        chk("collision_width", int'(servo_width), 1);

        // Randomized pulses and thresholds
        for (int n = 0; n < 20; n++) begin
            thr = 5'($urandom_range(0, 31));
            hi = $urandom_range(3, 140);
            lo = $urandom_range(D + 1, 100);
            pulse(hi, lo);
        end

        // Loopback-style stream: 10 ticks for 1, 3 ticks for 0, 31-tick frame
        thr = 5'd6;
        for (int n = 0; n < 12; n++) begin
            bv = 1'($urandom_range(0, 1));
            hi = bv ? 40 : 12;
            pulse(hi, 124 - hi);
            chk("loopback_value", int'(servo_value), int'(bv));
        end

        // Width saturation
        pulse(1100, 12);
        chk("width_sat", int'(servo_width), 255);

        // Timeout while high, then cleared by the next full pulse
        to_val = 8'd40;
        pulse(200, 12);
        chk("timeout_set", int'(servo_timeout), 1);
        pulse(20, 12);
        chk("timeout_clear", int'(servo_timeout), 0);
        to_val = 8'd0;

        // Reset mid-high with cnt = 7
        hold(1'b0, 8);
        er = k + D;
        do begin
            step(1'b1);
            if ((k - 1 == er) && m_from_low) m_period = ticks(m_last_er, er);
            check_outs(1'b0);
        end while (ticks(er, k) < 7);
        rst_n = 1'b0;
        model_clear();
        hold(1'b1, 1);
        hold(1'b0, 4);
        rst_n = 1'b1;
        hold(1'b0, 6);
        pulse(24, 16);
        chk("post_reset_width", int'(servo_width), m_width);

        // Disable mid-pulse behaves like reset
        pulse(40, 20);
        hold(1'b0, 2);
        servo_enabled = 1'b0;
        model_clear();
        hold(1'b1, 3);
        hold(1'b0, 3);
        servo_enabled = 1'b1;
        hold(1'b0, 6);
        pulse(30, 20);

`ifdef VSLC_SERVO_RX_FILTER_EN
        // A 2-cycle glitch is rejected; a 3-cycle high is accepted
        hold(1'b1, 2);
        hold(1'b0, 10);
        pulse(3, 12);
        chk("filter_accept_width", int'(servo_width), m_width);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
